// File: rtl/key_cmd_sched.sv
// Keyboard-to-game command scheduler: decodes set-2 make codes, adds DAS
// horizontal auto-repeat and soft-drop repeat, and queues commands in a 4-deep FIFO.
module key_cmd_sched #(
  parameter int unsigned DAS_DELAY   = 12_000_000,
  parameter int unsigned DAS_PERIOD  = 3_700_000,
  parameter int unsigned DROP_PERIOD = 2_500_000
) (
  input  logic       CLOCK_74,
  input  logic       reset,
  input  logic       valid_74,
  input  logic       makeBreak_74,
  input  logic [7:0] outCode_74,
  input  logic       enable,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready,
  output logic       overflow
);
  localparam int unsigned CNT_W  = 24;
  localparam int unsigned CMD_W  = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned FILL_W = 3;

  localparam logic [CMD_W-1:0] CMD_NONE   = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_LEFT   = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_RIGHT  = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_DOWN   = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_ROTATE = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_DROP   = CMD_W'(5);

  localparam logic [CNT_W-1:0] DLY_TERM  = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_TERM  = CNT_W'(DAS_PERIOD - 1);
  localparam logic [CNT_W-1:0] DROP_TERM = CNT_W'(DROP_PERIOD - 1);

  typedef enum logic [1:0] {H_IDLE, H_DELAY, H_REPEAT} hstate_e;

  hstate_e                     hstate_q, hstate_d;
  logic                        dir_q, dir_d;  // 0 = LEFT, 1 = RIGHT
  logic [CNT_W-1:0]            hcnt_q, hcnt_d;
  logic [CNT_W-1:0]            dcnt_q, dcnt_d;
  logic                        held_l_q, held_l_d, held_r_q, held_r_d, held_d_q, held_d_d;
  logic [DEPTH-1:0][CMD_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [FILL_W-1:0]           fill_q, fill_d;
  logic                        overflow_q, overflow_d;

  logic             is_l, is_r, is_d;
  logic [CMD_W-1:0] key_cmd;
  logic             typematic, key_push, hor_make;
  logic             act_held, oth_held, act_break, act_release;
  logic             h_term, d_rel, d_term;
  logic             pop, can_push, h_grant, d_grant, push;
  logic [CMD_W-1:0] push_cmd;
  logic [IDX_W-1:0] wr_idx;

  // Key decode
  always_comb begin
    key_cmd = CMD_NONE;
    case (outCode_74)
      8'h6B:   key_cmd = CMD_LEFT;
      8'h74:   key_cmd = CMD_RIGHT;
      8'h72:   key_cmd = CMD_DOWN;
      8'h75:   key_cmd = CMD_ROTATE;
      8'h29:   key_cmd = CMD_DROP;
      default: key_cmd = CMD_NONE;
    endcase
  end

  assign is_l      = (outCode_74 == 8'h6B);
  assign is_r      = (outCode_74 == 8'h74);
  assign is_d      = (outCode_74 == 8'h72);
  assign typematic = makeBreak_74 & ((is_l & held_l_q) | (is_r & held_r_q) | (is_d & held_d_q));
  assign key_push  = valid_74 & enable & makeBreak_74 & (key_cmd != CMD_NONE) & ~typematic;
  assign hor_make  = key_push & (is_l | is_r);

  // Held bits follow the keyboard even while paused
  always_comb begin
    held_l_d = held_l_q;
    held_r_d = held_r_q;
    held_d_d = held_d_q;
    if (valid_74) begin
      if (is_l) held_l_d = makeBreak_74;
      if (is_r) held_r_d = makeBreak_74;
      if (is_d) held_d_d = makeBreak_74;
    end
  end

  // A release seen while paused is resolved once the game resumes
  assign act_held    = dir_q ? held_r_q : held_l_q;
  assign oth_held    = dir_q ? held_l_q : held_r_q;
  assign act_break   = enable & valid_74 & ~makeBreak_74 & (dir_q ? is_r : is_l) & (hstate_q != H_IDLE);
  assign act_release = act_break | (enable & (hstate_q != H_IDLE) & ~act_held);
  assign h_term      = enable & ~hor_make & ~act_release &
                       (((hstate_q == H_DELAY) & (hcnt_q == DLY_TERM)) |
                        ((hstate_q == H_REPEAT) & (hcnt_q == RPT_TERM)));

  assign d_rel  = valid_74 & ~makeBreak_74 & is_d;
  assign d_term = enable & held_d_q & ~d_rel & (dcnt_q == DROP_TERM);

  // Single push port: key make beats horizontal repeat beats drop repeat
  assign pop      = vld_q[0] & cmd_ready;
  assign can_push = ~vld_q[DEPTH-1] | pop;
  assign h_grant  = h_term & ~key_push & can_push;
  assign d_grant  = d_term & ~key_push & ~h_term & can_push;
  assign push     = (key_push & can_push) | h_grant | d_grant;
  assign push_cmd = key_push ? key_cmd : (h_term ? (dir_q ? CMD_RIGHT : CMD_LEFT) : CMD_DOWN);
  assign wr_idx   = IDX_W'(fill_q - FILL_W'(pop));

  // Horizontal DAS FSM next state
  always_comb begin
    hstate_d = hstate_q;
    dir_d    = dir_q;
    hcnt_d   = hcnt_q;
    if (hor_make) begin
      hstate_d = H_DELAY;
      dir_d    = is_r;
      hcnt_d   = '0;
    end else if (act_release) begin
      hcnt_d = '0;
      if (oth_held) begin
        hstate_d = H_DELAY;
        dir_d    = ~dir_q;
      end else begin
        hstate_d = H_IDLE;
      end
    end else if (enable && hstate_q != H_IDLE) begin
      if (h_term) begin
        if (h_grant) begin
          hstate_d = H_REPEAT;
          hcnt_d   = '0;
        end
      end else begin
        hcnt_d = hcnt_q + CNT_W'(1);
      end
    end
  end

  // Soft-drop repeat counter
  always_comb begin
    dcnt_d = dcnt_q;
    if (!held_d_q || d_rel) begin
      dcnt_d = '0;
    end else if (enable) begin
      if (dcnt_q == DROP_TERM) begin
        if (d_grant) dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + CNT_W'(1);
      end
    end
  end

  // Shift FIFO: entry 0 is the head and drives the outputs directly
  always_comb begin
    data_d     = data_q;
    vld_d      = vld_q;
    fill_d     = fill_q - FILL_W'(pop) + FILL_W'(push);
    overflow_d = overflow_q | (key_push & ~can_push);
    if (pop) begin
      data_d = {CMD_NONE, data_q[DEPTH-1:1]};
      vld_d  = {1'b0, vld_q[DEPTH-1:1]};
    end
    if (push) begin
      data_d[wr_idx] = push_cmd;
      vld_d[wr_idx]  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_74 or posedge reset) begin
    if (reset) begin
      hstate_q   <= H_IDLE;
      dir_q      <= 1'b0;
      hcnt_q     <= '0;
      dcnt_q     <= '0;
      held_l_q   <= 1'b0;
      held_r_q   <= 1'b0;
      held_d_q   <= 1'b0;
      data_q     <= '0;
      vld_q      <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      hstate_q   <= hstate_d;
      dir_q      <= dir_d;
      hcnt_q     <= hcnt_d;
      dcnt_q     <= dcnt_d;
      held_l_q   <= held_l_d;
      held_r_q   <= held_r_d;
      held_d_q   <= held_d_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  assign cmd_valid = vld_q[0];
  assign cmd       = data_q[0];
  assign overflow  = overflow_q;

endmodule
